demux32_bit_1to2_buffered: RTL and testbench
============================================

Name: demux32_bit_1to2_buffered

Overview:
- Inverse of the 2:1 word mux used in the pipelined SAD datapath: takes one 32-bit word stream and steers each word to one of two destination lanes, A or B.
- Each lane has a small FIFO with a valid/ready handshake, so a stalled consumer on one lane does not drop data.
- Sits between the SAD accumulate stage and its two consumers, the writeback path and the debug/result port.
- Per-lane word counters support verification and performance checks.

Parameters:
- WIDTH, 32, data word width
- DEPTH, 2, entries per lane FIFO; power of two, 2 to 16
- CNT_W, 16, width of the per-lane delivered-word counters

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- inData  input  WIDTH  word to route
- sel  input  1  lane select: 1 routes to lane A, 0 routes to lane B (same polarity as the 2:1 mux)
- inValid  input  1  inData and sel are valid this cycle
- inReady  output  1  the selected lane can accept a word
- outDataA  output  WIDTH  head word of lane A
- outValidA  output  1  lane A is non-empty
- outReadyA  input  1  lane A consumer accepts the head word
- outDataB  output  WIDTH  head word of lane B
- outValidB  output  1  lane B is non-empty
- outReadyB  input  1  lane B consumer accepts the head word
- countA  output  CNT_W  words delivered on lane A
- countB  output  CNT_W  words delivered on lane B

Behaviour:
- Reset, asynchronous and active-high:
  - all FIFO pointers and occupancies go to 0
  - outValidA = outValidB = 0
  - outDataA = outDataB = 0
  - countA = countB = 0
  - takes effect immediately, mid-transfer included; in-flight words are discarded
- inReady is combinational from sel and the selected lane's full flag only: inReady = sel ? !fullA : !fullB.
  - It never depends on outReadyA or outReadyB, so there is no ready pass-through path.
- Push:
  - occurs when inValid && inReady at a rising edge of Clk
  - the word is written at the selected lane's write pointer and occupancy increments
  - only the selected lane changes
- Pop on lane X:
  - occurs when outValidX && outReadyX at a rising edge of Clk
  - read pointer advances, occupancy decrements, countX increments
- Latency: a word pushed at edge N appears on outDataX with outValidX = 1 after edge N, i.e. in cycle N+1.
- Per lane, outDataX is the registered head entry. It must hold stable while outValidX = 1 and !outReadyX.
- Ordering: order is preserved within a lane. There is no ordering relation between lanes.
- Simultaneous push and pop on the same lane:
  - occupancy is unchanged
  - when occupancy is 1, the pushed word becomes the new head on the next cycle
- Full lane (occupancy = DEPTH):
  - push is refused even if a pop occurs in the same cycle
  - inReady = 0 while that lane is selected
  - inValid may stay asserted; the source holds inData and sel
- Empty lane:
  - outValidX = 0 and outDataX holds its last value
  - outReadyX is ignored
- Pointer wrap: pointers wrap modulo DEPTH.
- Counter wrap: countA and countB wrap from 2^CNT_W-1 to 0 without a flag.
- sel with inValid = 0 has no effect.
- The lanes are independent: a pop on A and a push to B in the same cycle are both honoured.
- Lane state machine per lane, derived from occupancy:
  - EMPTY goes to PARTIAL on push without pop
  - PARTIAL goes to FULL when occupancy reaches DEPTH
  - FULL goes to PARTIAL on pop
  - PARTIAL goes to EMPTY on pop without push from occupancy 1
  - With DEPTH = 2, PARTIAL means occupancy 1.

Decomposition:
- No shared package is needed.
- WIDTH, DEPTH and CNT_W are parameters. Pointer width is derived as $clog2(DEPTH) local parameters.
- One sub-module, lane_fifo:
  - parameterised WIDTH and DEPTH
  - ports Clk, Reset, push, pushData, pop, headData, empty, full
  - instantiated twice
- The top level holds the select/ready logic and the counters.

Test Plan:
- Reset then idle: assert Reset for 3 cycles. Then inReady = 1, outValidA = 0, outValidB = 0, countA = 0, countB = 0, outDataA = 0, outDataB = 0.
- Routing and latency:
  - push 0x0000_00AA with sel = 1, then push 0x0000_00BB with sel = 0, with both outReady = 1
  - lane A shows 0xAA one cycle after its push; lane B shows 0xBB one cycle after its push
  - final state countA = 1, countB = 1
- Backpressure and full:
  - hold outReadyA = 0 and push 0x1, 0x2, 0x3 to lane A
  - the first two are accepted; inReady = 0 on the third and it is held
  - raise outReadyA: lane A delivers 0x1, 0x2, 0x3 in order, then countA = 3
- Lane independence: lane A full and stalled, sel = 0, push 0x55. It is accepted, delivered on lane B, and lane A contents are unchanged.
- Push and pop on the same cycle: lane B at occupancy 1 with head 0x10, push 0x20 while popping. Next cycle head = 0x20 and occupancy stays 1.
- Reset mid-operation and counter wrap:
  - with CNT_W = 4, deliver 17 words on lane A: countA = 1 after wrapping
  - assert Reset asynchronously between edges: outputs clear immediately and the held word is lost

Source files
------------

// File: rtl/lane_fifo.sv
// Single-lane FIFO with a registered head word.
// Ports: Clk/Reset (async, active-high); push/pushData write one entry (ignored when full);
//        pop consumes the head (ignored when empty); headData, empty, full describe the lane.
module lane_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] headData,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign empty    = (occ_q == '0);
  assign full     = (occ_q == OCC_W'(DEPTH));
  assign headData = head_q;

  // A full lane refuses a push even when it is popped in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    head_d   = head_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    // The head is kept in its own register so that an empty lane still shows
    // the last word it delivered, and a fresh push is visible one cycle later.
    if (do_pop) begin
      if (occ_q > OCC_W'(1)) head_d = mem_q[rd_ptr_q + PTR_W'(1)];
      else if (do_push)      head_d = pushData;
    end else if (do_push && empty) begin
      head_d = pushData;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      head_q   <= head_d;
    end
  end

  // Storage needs no reset: occupancy decides which entries are meaningful.
  always_ff @(posedge Clk) begin
    if (do_push) mem_q[wr_ptr_q] <= pushData;
  end

endmodule

// File: rtl/demux32_bit_1to2_buffered.sv
// 1:2 word demultiplexer with a small FIFO per destination lane and per-lane delivery counters.
// Ports: Clk/Reset (async, active-high); inData/sel/inValid/inReady input stream (sel=1 -> lane A);
//        outDataX/outValidX/outReadyX per-lane output handshakes; countA/countB delivered-word counts.
module demux32_bit_1to2_buffered #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] inData,
  input  logic             sel,
  input  logic             inValid,
  output logic             inReady,
  output logic [WIDTH-1:0] outDataA,
  output logic             outValidA,
  input  logic             outReadyA,
  output logic [WIDTH-1:0] outDataB,
  output logic             outValidB,
  input  logic             outReadyB,
  output logic [CNT_W-1:0] countA,
  output logic [CNT_W-1:0] countB
);

  logic             empty_a, full_a, empty_b, full_b;
  logic             push_a, push_b, pop_a, pop_b;
  logic [CNT_W-1:0] count_a_q, count_a_d, count_b_q, count_b_d;

  // Ready looks only at the selected lane's full flag, never at the consumers.
  assign inReady = sel ? !full_a : !full_b;
  assign push_a  = inValid && inReady && sel;
  assign push_b  = inValid && inReady && !sel;

  assign outValidA = !empty_a;
  assign outValidB = !empty_b;
  assign pop_a     = outValidA && outReadyA;
  assign pop_b     = outValidB && outReadyB;

  lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane_a (
    .Clk      (Clk),
    .Reset    (Reset),
    .push     (push_a),
    .pushData (inData),
    .pop      (pop_a),
    .headData (outDataA),
    .empty    (empty_a),
    .full     (full_a)
  );

  lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane_b (
    .Clk      (Clk),
    .Reset    (Reset),
    .push     (push_b),
    .pushData (inData),
    .pop      (pop_b),
    .headData (outDataB),
    .empty    (empty_b),
    .full     (full_b)
  );

  // Counters wrap silently.
  always_comb begin
    count_a_d = count_a_q;
    count_b_d = count_b_q;
    if (pop_a) count_a_d = count_a_q + CNT_W'(1);
    if (pop_b) count_b_d = count_b_q + CNT_W'(1);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_a_q <= '0;
      count_b_q <= '0;
    end else begin
      count_a_q <= count_a_d;
      count_b_q <= count_b_d;
    end
  end

  assign countA = count_a_q;
  assign countB = count_b_q;

endmodule

// File: tb/tb_demux32_bit_1to2_buffered.sv
// Bench for demux32_bit_1to2_buffered: queue-based lane model plus directed and random stimulus.
module tb_demux32_bit_1to2_buffered;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic [WIDTH-1:0] inData = '0;
  logic             sel = 1'b0;
  logic             inValid = 1'b0;
  logic             inReady;
  logic [WIDTH-1:0] outDataA, outDataB;
  logic             outValidA, outValidB;
  logic             outReadyA = 1'b0;
  logic             outReadyB = 1'b0;
  logic [CNT_W-1:0] countA, countB;

  int tests = 0;
  int fails = 0;

  demux32_bit_1to2_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .inData    (inData),
    .sel       (sel),
    .inValid   (inValid),
    .inReady   (inReady),
    .outDataA  (outDataA),
    .outValidA (outValidA),
    .outReadyA (outReadyA),
    .outDataB  (outDataB),
    .outValidB (outValidB),
    .outReadyB (outReadyB),
    .countA    (countA),
    .countB    (countB)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  // Reference model: each lane is a queue of words; an empty lane shows the last word it delivered.
  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  logic [WIDTH-1:0] last_a = '0;
  logic [WIDTH-1:0] last_b = '0;
  int unsigned      cnt_a = 0;
  int unsigned      cnt_b = 0;
  bit               m_rdy, m_pa, m_pb;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      qa.delete();
      qb.delete();
      last_a = '0;
      last_b = '0;
      cnt_a  = 0;
      cnt_b  = 0;
    end else begin
      m_rdy = sel ? (qa.size() < DEPTH) : (qb.size() < DEPTH);
      m_pa  = (qa.size() > 0) && outReadyA;
      m_pb  = (qb.size() > 0) && outReadyB;
      if (m_pa) begin last_a = qa.pop_front(); cnt_a++; end
      if (m_pb) begin last_b = qb.pop_front(); cnt_b++; end
      if (inValid && m_rdy) begin
        if (sel) qa.push_back(inData);
        else     qb.push_back(inData);
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (!Reset) begin
      check("inReady", {31'b0, inReady},
            {31'b0, (sel ? (qa.size() < DEPTH) : (qb.size() < DEPTH))});
      check("outValidA", {31'b0, outValidA}, {31'b0, (qa.size() > 0)});
      check("outValidB", {31'b0, outValidB}, {31'b0, (qb.size() > 0)});
      check("outDataA", outDataA, (qa.size() > 0) ? qa[0] : last_a);
      check("outDataB", outDataB, (qb.size() > 0) ? qb[0] : last_b);
      check("countA", {28'b0, countA}, cnt_a % (1 << CNT_W));
      check("countB", {28'b0, countB}, cnt_b % (1 << CNT_W));
    end
  end

  initial begin
    // Reset then idle
    repeat (3) @(posedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("rst_inReady", {31'b0, inReady}, 32'd1);
    check("rst_validA", {31'b0, outValidA}, 32'd0);
    check("rst_validB", {31'b0, outValidB}, 32'd0);
    check("rst_countA", {28'b0, countA}, 32'd0);
    check("rst_countB", {28'b0, countB}, 32'd0);
    check("rst_dataA", outDataA, 32'd0);
    check("rst_dataB", outDataB, 32'd0);

    // Routing and one-cycle latency
    outReadyA = 1; outReadyB = 1;
    inValid = 1; sel = 1; inData = 32'hAA;
    tick();
    check("route_validA", {31'b0, outValidA}, 32'd1);
    check("route_dataA", outDataA, 32'hAA);
    sel = 0; inData = 32'hBB;
    tick();
    check("route_validB", {31'b0, outValidB}, 32'd1);
    check("route_dataB", outDataB, 32'hBB);
    check("route_countA", {28'b0, countA}, 32'd1);
    check("route_holdA", outDataA, 32'hAA);
    inValid = 0;
    tick();
    check("route_countB", {28'b0, countB}, 32'd1);

    // Backpressure and full lane A
    outReadyA = 0;
    inValid = 1; sel = 1; inData = 32'h1;
    tick();
    inData = 32'h2;
    tick();
    inData = 32'h3;
    #1 check("full_inReady", {31'b0, inReady}, 32'd0);
    tick();
    check("full_held", {31'b0, inReady}, 32'd0);
    check("full_head", outDataA, 32'h1);
    outReadyA = 1;
    tick();
    check("drain_head2", outDataA, 32'h2);
    check("drain_cnt", {28'b0, countA}, 32'd2);
    tick();
    check("drain_head3", outDataA, 32'h3);
    inValid = 0;
    tick();
    // one word from the routing test plus 0x1, 0x2, 0x3
    check("drain_countA", {28'b0, countA}, 32'd4);
    check("drain_emptyA", {31'b0, outValidA}, 32'd0);

    // Lane independence: A full and stalled, B still accepts
    outReadyA = 0; outReadyB = 0;
    inValid = 1; sel = 1; inData = 32'hA1;
    tick();
    inData = 32'hA2;
    tick();
    sel = 0; inData = 32'h55;
    #1 check("indep_ready", {31'b0, inReady}, 32'd1);
    tick();
    check("indep_dataB", outDataB, 32'h55);
    check("indep_dataA", outDataA, 32'hA1);
    inValid = 0; sel = 1;
    #1 check("indep_readyA", {31'b0, inReady}, 32'd0);
    outReadyA = 1; outReadyB = 1;
    repeat (3) tick();
    check("indep_cntA", {28'b0, countA}, 32'd6);
    check("indep_cntB", {28'b0, countB}, 32'd2);

    // Push and pop on the same cycle at occupancy 1
    outReadyB = 0;
    inValid = 1; sel = 0; inData = 32'h10;
    tick();
    check("pp_head10", outDataB, 32'h10);
    outReadyB = 1; inData = 32'h20;
    tick();
    check("pp_head20", outDataB, 32'h20);
    check("pp_valid", {31'b0, outValidB}, 32'd1);
    inValid = 0; outReadyB = 0;
    tick();
    check("pp_stable", outDataB, 32'h20);
    outReadyB = 1;
    tick();
    check("pp_occ1", {31'b0, outValidB}, 32'd0);
    check("pp_cntB", {28'b0, countB}, 32'd4);

    // Counter wrap: 17 words on lane A from a fresh reset
    #1 Reset = 1;
    tick();
    Reset = 0;
    check("wrap_rst", {28'b0, countA}, 32'd0);
    outReadyA = 1; inValid = 1; sel = 1;
    for (int i = 0; i < 17; i++) begin
      inData = 32'h100 + i;
      tick();
    end
    inValid = 0;
    repeat (2) tick();
    check("wrap_countA", {28'b0, countA}, 32'd1);
    check("wrap_lastA", outDataA, 32'h110);

    // Asynchronous reset between edges discards a held word
    outReadyA = 0; inValid = 1; sel = 1; inData = 32'h77;
    tick();
    inValid = 0;
    check("async_pre", outDataA, 32'h77);
    #1 Reset = 1;
    #1;
    check("async_valid", {31'b0, outValidA}, 32'd0);
    check("async_data", outDataA, 32'd0);
    check("async_cnt", {28'b0, countA}, 32'd0);
    tick();
    Reset = 0;
    tick();
    check("async_lost", {31'b0, outValidA}, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      inValid   = ($urandom_range(0, 3) != 0);
      sel       = $urandom_range(0, 1);
      inData    = $urandom;
      outReadyA = ($urandom_range(0, 2) != 0);
      outReadyB = ($urandom_range(0, 3) == 0);
      tick();
    end
    inValid = 0; outReadyA = 1; outReadyB = 1;
    repeat (4) tick();
    check("end_emptyA", {31'b0, outValidA}, 32'd0);
    check("end_emptyB", {31'b0, outValidB}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
